// File: rtl/uart_error_monitor.sv
// uart_error_monitor: sticky UART RX error flags, saturating counters, break/timeout detection, maskable irq
//
// Sits between the RX bit/frame FSM and the register interface.
// Class bit order everywhere: {overrun, timeout, break, parity, frame}.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   frame_error     stop-bit error pulse (suppressed while a break is active)
//   parity_error    parity mismatch pulse
//   overrun_error   RX FIFO overrun pulse
//   frame_active    high while the RX FSM is inside a frame
//   bit_valid       strobe at each bit mid-sample point
//   rx_filtered     synchronised RX line, idle high
//   cycles_per_bit  clocks per bit period
//   timeout_bits    idle bit periods before a character timeout, 0 disables
//   err_clear       write-1-to-clear per status bit
//   cnt_clear       zero all error counters
//   irq_mask        per-class interrupt enable
//   err_status      sticky error flags
//   err_count       per-class saturating counters, class i at [i*CNT_W +: CNT_W]
//   first_error     class of the first error since status was clear, 3'b111 = none
//   error_detected  any status bit set
//   irq             any enabled status bit set
//   break_active    line currently held in break
//
// Build option: define UART_ERR_COUNTERS_EN to implement the error counters;
// otherwise err_count reads 0 and cnt_clear is ignored.
module uart_error_monitor #(
  parameter int CNT_W      = 8,
  parameter int CPB_W      = 16,
  parameter int TO_W       = 4,
  parameter int BREAK_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_error,
  input  logic                 parity_error,
  input  logic                 overrun_error,
  input  logic                 frame_active,
  input  logic                 bit_valid,
  input  logic                 rx_filtered,
  input  logic [CPB_W-1:0]     cycles_per_bit,
  input  logic [TO_W-1:0]      timeout_bits,
  input  logic [4:0]           err_clear,
  input  logic                 cnt_clear,
  input  logic [4:0]           irq_mask,
  output logic [4:0]           err_status,
  output logic [5*CNT_W-1:0]   err_count,
  output logic [2:0]           first_error,
  output logic                 error_detected,
  output logic                 irq,
  output logic                 break_active
);
  localparam int TW = CPB_W + TO_W;
  localparam int BW = $clog2(BREAK_BITS + 1);
  localparam logic [TW:0] TWO = 2;
  typedef enum logic [1:0] {B_IDLE, B_COUNT, B_ACTIVE} bstate_t;
  typedef enum logic {T_IDLE, T_ARMED} tstate_t;
  bstate_t         b_q;
  logic [BW-1:0]   bcnt_q;
  logic            brk_q;
  tstate_t         t_q;
  logic [TW-1:0]   tcnt_q, thr_q, thr_now;
  logic            fa_q;
  logic [4:0]      st_q, st_d, ev;
  logic [2:0]      fe_q, fe_d, fe_idx;
  logic            det_q, irq_q, brk_ev, to_ev;
  assign thr_now = TW'(cycles_per_bit) * TW'(timeout_bits);
  // Break fires on the strobe that completes BREAK_BITS consecutive low samples.
  assign brk_ev = b_q == B_COUNT && bit_valid && !rx_filtered && bcnt_q == BW'(BREAK_BITS - 1);
  // Fires when the idle counter steps onto threshold-1.
  assign to_ev  = t_q == T_ARMED && !frame_active && rx_filtered && ({1'b0, tcnt_q} + TWO >= {1'b0, thr_q});
  assign ev     = {overrun_error, to_ev, brk_ev, parity_error, frame_error && b_q != B_ACTIVE};
  assign st_d   = (st_q & ~err_clear) | ev;
  assign fe_idx = ev[0] ? 3'd0 : ev[1] ? 3'd1 : ev[2] ? 3'd2 : ev[3] ? 3'd3 : 3'd4;
  assign fe_d   = (st_q == '0 && |ev) ? fe_idx : st_d == '0 ? 3'b111 : fe_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= '0;
      fe_q  <= 3'b111;
      det_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      fe_q  <= fe_d;
      det_q <= |st_d;
      irq_q <= |(st_d & irq_mask);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q    <= B_IDLE;
      bcnt_q <= '0;
      brk_q  <= 1'b0;
    end else begin
      case (b_q)
        B_IDLE: if (bit_valid && !rx_filtered) begin
          b_q    <= B_COUNT;
          bcnt_q <= BW'(1);
        end
        B_COUNT: if (rx_filtered) begin
          b_q    <= B_IDLE;
          bcnt_q <= '0;
        end else if (brk_ev) begin
          b_q    <= B_ACTIVE;
          bcnt_q <= '0;
          brk_q  <= 1'b1;
        end else if (bit_valid) bcnt_q <= bcnt_q + 1'b1;
        B_ACTIVE: if (rx_filtered) begin
          b_q   <= B_IDLE;
          brk_q <= 1'b0;
        end
        default: b_q <= B_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q    <= T_IDLE;
      tcnt_q <= '0;
      thr_q  <= '0;
      fa_q   <= 1'b0;
    end else begin
      fa_q <= frame_active;
      case (t_q)
        T_IDLE: if (fa_q && !frame_active && thr_now != '0) begin
          t_q    <= T_ARMED;
          tcnt_q <= '0;
          thr_q  <= thr_now;
        end
        T_ARMED: if (frame_active) t_q <= T_IDLE;
        else if (!rx_filtered) tcnt_q <= '0;
        else if (to_ev) t_q <= T_IDLE;
        else tcnt_q <= tcnt_q + 1'b1;
        default: t_q <= T_IDLE;
      endcase
    end
  end
`ifdef UART_ERR_COUNTERS_EN
  logic [4:0][CNT_W-1:0] cnt_q;
  // A clear coinciding with an event leaves the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else for (int i = 0; i < 5; i++)
      cnt_q[i] <= cnt_clear ? CNT_W'(ev[i]) : cnt_q[i] + CNT_W'(ev[i] && cnt_q[i] != '1);
  end
  assign err_count = cnt_q;
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign err_count = '0;
`endif
  assign err_status     = st_q;
  assign first_error    = fe_q;
  assign error_detected = det_q;
  assign irq            = irq_q;
  assign break_active   = brk_q;
endmodule
